bcd_convert_arbiter: RTL

BCD_CONVERT_ARBITER -- requirements
Module: bcd_convert_arbiter

---
 rtl/bcd_convert_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/bcd_convert_arbiter.sv
// Two-requester binary-to-BCD converter: round-robin grant, then a fixed-latency
// double-dabble conversion of the granted operand into four packed BCD digits.
module bcd_convert_arbiter #(
    parameter int IN_W = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic [IN_W-1:0] bin0,
    input  logic [IN_W-1:0] bin1,
    output logic [1:0]      gnt,
    output logic            busy,
    output logic            done,
    output logic            done_id,
    output logic [15:0]     bcd
);

    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      digits;
    logic [IN_W-1:0]  op;
    logic             id;

    logic             pick;
    logic [15:0]      adj;
    logic [15:0]      digits_next;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (!rst && state == IDLE && req != '0) begin
            gnt = pick ? 2'b10 : 2'b01;
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        adj = digits;
        for (int unsigned i = 0; i < 4; i++) begin
            if (digits[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
            end
        end
    end

    // Thousands carry-out is dropped, so values above 9999 keep the low 4 digits.
    assign digits_next = {adj[14:0], op[IN_W-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= '0;
            digits  <= '0;
            op      <= '0;
            id      <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (req != '0) begin
                        op     <= pick ? bin1 : bin0;
                        id     <= pick;
                        last   <= pick;
                        cnt    <= CNT_W'(IN_W);
                        digits <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    digits <= digits_next;
                    op     <= op << 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd     <= digits_next;
                        done    <= 1'b1;
                        done_id <= id;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
